// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared constants for the input conditioner. Holds the coin
//               denominations, the bit position of each coin switch on the
//               raw switch bus, and a helper that totals the credit of a set
//               of simultaneous coin edges.
// Revision    : 1.0  initial release
// ============================================================================
package input_conditioner_pkg;

    // Width of a single-cycle coin total (max 1+5+10+20 = 36).
    localparam int COIN_SUM_W = 7;

    localparam logic [COIN_SUM_W-1:0] COIN_1  = 7'd1;
    localparam logic [COIN_SUM_W-1:0] COIN_5  = 7'd5;
    localparam logic [COIN_SUM_W-1:0] COIN_10 = 7'd10;
    localparam logic [COIN_SUM_W-1:0] COIN_20 = 7'd20;

    localparam int SW_BIT_1  = 0;
    localparam int SW_BIT_5  = 1;
    localparam int SW_BIT_10 = 2;
    localparam int SW_BIT_20 = 3;

    // Total credit represented by the coin edges seen in one cycle.
    function automatic logic [COIN_SUM_W-1:0] coin_sum(input logic [3:0] rise);
        logic [COIN_SUM_W-1:0] total;
        total = '0;
        if (rise[SW_BIT_1])  total = total + COIN_1;
        if (rise[SW_BIT_5])  total = total + COIN_5;
        if (rise[SW_BIT_10]) total = total + COIN_10;
        if (rise[SW_BIT_20]) total = total + COIN_20;
        return total;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : Two-flop synchroniser followed by a stability counter. A new
//               level is accepted only after the synchronised input has
//               disagreed with the accepted level for DEBOUNCE_CYCLES
//               consecutive clocks. A registered one-cycle pulse marks each
//               accepted rising edge.
// Ports       : clk    - system clock
//               rst    - asynchronous active-low reset
//               raw    - asynchronous raw input
//               stable - debounced level
//               rise   - one-cycle pulse on each accepted rising edge
// Revision    : 1.0  initial release
// ============================================================================
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic w_mismatch;
    logic w_accept;

    assign w_mismatch = (r_sync2 != r_stable);
    // The counter has already seen DEBOUNCE_CYCLES-1 mismatching clocks, so
    // this clock is the DEBOUNCE_CYCLES-th one.
    assign w_accept   = w_mismatch && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_accept && r_sync2;
            if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else if (w_mismatch) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign stable = r_stable;
    assign rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Front end of the vending-machine controller. Debounces the
//               three buttons and four coin switches, holds each button press
//               as a pending flag until the controller's sampling tick, and
//               accumulates coin credit (saturating) until the next tick.
// Ports       : clk, rst (async active-low)
//               L_button, R_button, C_button - raw buttons
//               switch[3:0]  - raw coin switches (1, 5, 10, 20 units)
//               tick         - consumer sampling strobe
//               inhibit      - reject coins while high
//               l_evt, r_evt, c_evt - pending button presses
//               coin_valid, coin_value - pending credit
//               coin_reject  - one-cycle pulse per discarded coin cycle
// Revision    : 1.0  initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16,
    parameter int COIN_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              L_button,
    input  logic              R_button,
    input  logic              C_button,
    input  logic [3:0]        switch,
    input  logic              tick,
    input  logic              inhibit,
    output logic              l_evt,
    output logic              r_evt,
    output logic              c_evt,
    output logic              coin_valid,
    output logic [COIN_W-1:0] coin_value,
    output logic              coin_reject
);

    // Wide enough for a saturated value plus a full single-cycle total.
    localparam int                 c_ACC_W = COIN_W + COIN_SUM_W;
    localparam logic [COIN_W-1:0]  c_MAX   = {COIN_W{1'b1}};

    logic [6:0] w_raw;
    logic [6:0] w_stable;
    logic [6:0] w_rise;

    assign w_raw = {switch, C_button, R_button, L_button};

    for (genvar gi = 0; gi < 7; gi++) begin : g_cells
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .raw    (w_raw[gi]),
            .stable (w_stable[gi]),
            .rise   (w_rise[gi])
        );
    end

    // ------------------------------------------------------------------
    // Button pending flags: a new event beats a simultaneous tick.
    // ------------------------------------------------------------------
    logic [2:0] r_btn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn <= '0;
        end else begin
            r_btn <= w_rise[2:0] | (r_btn & {3{~tick}});
        end
    end

    // ------------------------------------------------------------------
    // Coin accumulation
    // ------------------------------------------------------------------
    logic [3:0]            w_coin_rise;
    logic [COIN_SUM_W-1:0] w_sum;
    logic [COIN_W-1:0]     w_base;
    logic [c_ACC_W-1:0]    w_acc;
    logic [COIN_W-1:0]     w_val_nxt;
    logic                  w_valid_nxt;
    logic                  w_rej_nxt;

    logic [COIN_W-1:0]     r_coin_value;
    logic                  r_coin_valid;
    logic                  r_coin_reject;

    assign w_coin_rise = w_rise[6:3];
    assign w_sum       = coin_sum(w_coin_rise);
    // A tick hands the current credit to the consumer, so any coin landing
    // in the same cycle starts a fresh total instead of being lost.
    assign w_base      = tick ? '0 : r_coin_value;
    assign w_acc       = c_ACC_W'(w_base) + c_ACC_W'(w_sum);

    always_comb begin
        w_val_nxt   = w_base;
        w_valid_nxt = r_coin_valid & ~tick;
        w_rej_nxt   = 1'b0;
        if (|w_coin_rise) begin
            if (inhibit) begin
                w_rej_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b1;
                w_val_nxt   = (w_acc > c_ACC_W'(c_MAX)) ? c_MAX : w_acc[COIN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_coin_value  <= '0;
            r_coin_valid  <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_value  <= w_val_nxt;
            r_coin_valid  <= w_valid_nxt;
            r_coin_reject <= w_rej_nxt;
        end
    end

    // Debounced levels are only needed for edge detection inside the cells.
    logic w_unused;
    assign w_unused = ^w_stable;

    assign l_evt       = r_btn[0];
    assign r_evt       = r_btn[1];
    assign c_evt       = r_btn[2];
    assign coin_valid  = r_coin_valid;
    assign coin_value  = r_coin_value;
    assign coin_reject = r_coin_reject;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Directed self-checking bench for input_conditioner with a
//               cycle-level behavioural model and literal spot checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_input_conditioner;

    localparam int D      = 8;
    localparam int CNT_W  = 4;
    localparam int COIN_W = 6;
    localparam int LAT    = 2 + D + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              L_button, R_button, C_button;
    logic [3:0]        switch;
    logic              tick, inhibit;
    logic              l_evt, r_evt, c_evt;
    logic              coin_valid;
    logic [COIN_W-1:0] coin_value;
    logic              coin_reject;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CNT_W),
        .COIN_W          (COIN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .L_button    (L_button),
        .R_button    (R_button),
        .C_button    (C_button),
        .switch      (switch),
        .tick        (tick),
        .inhibit     (inhibit),
        .l_evt       (l_evt),
        .r_evt       (r_evt),
        .c_evt       (c_evt),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .coin_reject (coin_reject)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Each input is seen through a two-cycle delay; its
    // accepted level flips once the delayed level has disagreed with it for
    // D consecutive clocks. An accepted rising edge reaches the outputs one
    // clock later.
    // ------------------------------------------------------------------
    int m_d1[7], m_d2[7], m_level[7], m_run[7], m_edge[7];
    int m_flag[3];
    int m_val, m_valid, m_rej;

    task automatic model_clear();
        for (int i = 0; i < 7; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_edge[i] = 0;
        end
        for (int b = 0; b < 3; b++) m_flag[b] = 0;
        m_val = 0; m_valid = 0; m_rej = 0;
    endtask

    task automatic model_edge();
        int raw[7];
        int sum;
        int new_edge[7];
        if (!rst) begin
            model_clear();
            return;
        end
        raw[0] = int'(L_button); raw[1] = int'(R_button); raw[2] = int'(C_button);
        for (int k = 0; k < 4; k++) raw[3+k] = int'(switch[k]);

        for (int b = 0; b < 3; b++)
            m_flag[b] = (m_edge[b] != 0 || (m_flag[b] != 0 && !tick)) ? 1 : 0;

        sum = m_edge[3]*1 + m_edge[4]*5 + m_edge[5]*10 + m_edge[6]*20;
        m_rej = 0;
        if (tick) begin m_val = 0; m_valid = 0; end
        if (sum > 0) begin
            if (inhibit) m_rej = 1;
            else begin
                m_val   = (m_val + sum > 63) ? 63 : m_val + sum;
                m_valid = 1;
            end
        end

        for (int i = 0; i < 7; i++) begin
            new_edge[i] = 0;
            if (m_d2[i] != m_level[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == D) begin
                m_level[i] = m_d2[i];
                m_run[i]   = 0;
                new_edge[i] = m_level[i];
            end
            m_edge[i] = new_edge[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = raw[i];
        end
    endtask

    task automatic compare_all();
        check("l_evt",       int'(l_evt),       m_flag[0]);
        check("r_evt",       int'(r_evt),       m_flag[1]);
        check("c_evt",       int'(c_evt),       m_flag[2]);
        check("coin_valid",  int'(coin_valid),  m_valid);
        check("coin_value",  int'(coin_value),  m_val);
        check("coin_reject", int'(coin_reject), m_rej);
    endtask

    int n_c_rise = 0;
    int n_rej    = 0;
    logic c_prev = 1'b0;

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
            if (c_evt && !c_prev) n_c_rise++;
            c_prev = c_evt;
            if (coin_reject) n_rej++;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(1); tick = 1'b0;
    endtask

    initial begin
        rst = 1'b0; L_button = 0; R_button = 0; C_button = 0;
        switch = '0; tick = 0; inhibit = 0;
        model_clear();
        #1;
        compare_all();
        check("reset_value", int'(coin_value), 0);
        step(3);
        rst = 1'b1;
        step(2);

        // Left button latency, tick clear, no repeat while held.
        L_button = 1'b1;
        step(LAT - 1);
        check("l_latency_before", int'(l_evt), 0);
        step(1);
        check("l_latency_at", int'(l_evt), 1);
        step(5);
        pulse_tick();
        check("l_cleared_by_tick", int'(l_evt), 0);
        step(3 * D);
        check("l_no_repeat", int'(l_evt), 0);
        L_button = 1'b0;
        step(D + 4);

        // Bouncing confirm button.
        n_c_rise = 0;
        for (int t = 0; t < 10; t++) begin
            C_button = ~C_button;
            step(D - 1);
        end
        C_button = 1'b1;
        step(LAT + 3);
        check("c_single_event", n_c_rise, 1);
        pulse_tick();
        C_button = 1'b0;
        step(D + 4);

        // 5 + 10 between ticks.
        switch[1] = 1'b1; step(D + 4); switch[1] = 1'b0; step(D + 4);
        switch[2] = 1'b1; step(D + 4); switch[2] = 1'b0; step(D + 4);
        check("coin_15_valid", int'(coin_valid), 1);
        check("coin_15_value", int'(coin_value), 15);
        // A 1-unit coin landing on the tick cycle starts a fresh total.
        switch[0] = 1'b1;
        step(LAT - 1);
        pulse_tick();
        check("coin_tick_fresh", int'(coin_value), 1);
        check("coin_tick_valid", int'(coin_valid), 1);
        switch[0] = 1'b0; step(D + 4);
        pulse_tick();
        check("coin_clear_value", int'(coin_value), 0);
        check("coin_clear_valid", int'(coin_valid), 0);

        // All four together, then saturation.
        for (int r = 0; r < 3; r++) begin
            switch = 4'hF; step(D + 4); switch = 4'h0; step(D + 4);
            if (r == 0) check("coin_36", int'(coin_value), 36);
        end
        check("coin_sat", int'(coin_value), 63);
        pulse_tick();

        // Inhibited coin, then accepted coin.
        inhibit = 1'b1; n_rej = 0;
        switch[3] = 1'b1; step(D + 4); switch[3] = 1'b0; step(D + 4);
        check("reject_pulses", n_rej, 1);
        check("reject_no_valid", int'(coin_valid), 0);
        inhibit = 1'b0;
        switch[3] = 1'b1; step(D + 4); switch[3] = 1'b0; step(D + 4);
        check("coin_20", int'(coin_value), 20);
        pulse_tick();

        // Right button event on the tick cycle.
        R_button = 1'b1;
        step(LAT - 1);
        pulse_tick();
        check("r_set_wins", int'(r_evt), 1);
        step(3);
        pulse_tick();
        check("r_next_tick", int'(r_evt), 0);
        R_button = 1'b0;
        step(D + 4);

        // Reset mid-count with release before reset ends.
        L_button = 1'b1; switch[2] = 1'b1;
        step(D / 2);
        rst = 1'b0; #1; model_clear();
        compare_all();
        step(2);
        L_button = 1'b0; switch[2] = 1'b0;
        rst = 1'b1;
        step(3 * D);
        check("rst_no_event", int'(l_evt), 0);

        // Held through reset: full latency from reset release.
        L_button = 1'b1;
        step(D / 2);
        rst = 1'b0; #1; model_clear();
        compare_all();
        step(2);
        rst = 1'b1;
        step(LAT - 1);
        check("rst_hold_before", int'(l_evt), 0);
        step(1);
        check("rst_hold_event", int'(l_evt), 1);
        L_button = 1'b0;
        pulse_tick();
        step(D + 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
